// File: rtl/fp_wrb_port_arbiter_pkg.sv
// fp_wrb_pkg: shared types and constants for the FP writeback port arbiter.
// Holds the buffered entry type, producer index map and one-hot decode helper.
package fp_wrb_pkg;

   localparam int FP_WRB_NUM_REQ     = 4;
   localparam int FP_WRB_ADDR_WIDTH  = 6;
   localparam int FP_WRB_DATA_WIDTH  = 64;

   // Producer index assignments
   localparam int FP_WRB_IDX_FALU1    = 0;
   localparam int FP_WRB_IDX_FALU2    = 1;
   localparam int FP_WRB_IDX_LSU      = 2;
   localparam int FP_WRB_IDX_FDIVSQRT = 3;

   typedef struct packed {
      logic [FP_WRB_ADDR_WIDTH-1:0] addr;
      logic [FP_WRB_DATA_WIDTH-1:0] data;
   } wrb_entry_t;

   // Convert a one-hot grant to a 2-bit producer index (0 for an empty grant)
   function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
      logic [1:0] idx;
      case (oh)
         4'b0001: idx = 2'd0;
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/fp_wrb_port_arbiter_rr_pick2.sv
// rr_pick2: combinational two-grant round-robin picker.
// Scans from ptr upward (mod 4); first eligible index gets grant_first,
// the next eligible one after it gets grant_second.
module rr_pick2
   import fp_wrb_pkg::*;
(
   input  logic [3:0] eligible,
   input  logic [1:0] ptr,
   output logic [3:0] grant_first,
   output logic [3:0] grant_second,
   output logic       valid_first,
   output logic       valid_second
);

   logic [1:0] idx_s;

   // Walk the four slots in rotation order and hand out at most two grants
   always_comb begin
      grant_first  = 4'b0000;
      grant_second = 4'b0000;
      valid_first  = 1'b0;
      valid_second = 1'b0;
      idx_s        = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx_s = ptr + 2'(k);
         if (eligible[idx_s]) begin
            if (!valid_first) begin
               grant_first[idx_s] = 1'b1;
               valid_first        = 1'b1;
            end else if (!valid_second) begin
               grant_second[idx_s] = 1'b1;
               valid_second        = 1'b1;
            end else begin
               valid_second = valid_second;
            end
         end else begin
            valid_first = valid_first;
         end
      end
   end

endmodule

// File: rtl/fp_wrb_port_arbiter.sv
// fp_wrb_port_arbiter: merges four FP writeback producers onto the two
// write ports of the FP physical register file. Each producer owns a
// one-entry holding buffer; a round-robin picker drains up to two per cycle.
// Entries targeting register 0 are silently dropped.
// Optional macro FP_WRB_PERF_CNT_EN adds a saturating stall counter output.
module fp_wrb_port_arbiter
   import fp_wrb_pkg::*;
#(
   parameter int REG_SIZE_WIDTH = FP_WRB_ADDR_WIDTH,
   parameter int DATA_WIDTH     = FP_WRB_DATA_WIDTH,
   parameter int NUM_REQ        = FP_WRB_NUM_REQ
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_valid_i,
   output logic [NUM_REQ-1:0]              req_ready_o,
   input  logic [NUM_REQ*REG_SIZE_WIDTH-1:0] req_addr_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
   output logic                            wr_first_valid_o,
   output logic [REG_SIZE_WIDTH-1:0]       wr_first_address_o,
   output logic [DATA_WIDTH-1:0]           wr_first_data_o,
   output logic                            wr_second_valid_o,
   output logic [REG_SIZE_WIDTH-1:0]       wr_second_address_o,
   output logic [DATA_WIDTH-1:0]           wr_second_data_o,
`ifdef FP_WRB_PERF_CNT_EN
   output logic [31:0]                     stall_cnt_o,
`endif
   output logic                            busy_o
);

   wrb_entry_t       buf_r [NUM_REQ];
   logic [3:0]       buf_valid_r;
   logic [1:0]       ptr_r;

   logic [3:0]       eligible_s;
   logic [3:0]       drop_s;
   logic [3:0]       grant_first_s;
   logic [3:0]       grant_second_s;
   logic [3:0]       grant_s;
   logic [3:0]       ready_s;
   logic             valid_first_s;
   logic             valid_second_s;
   logic [1:0]       idx_first_s;
   logic [1:0]       idx_second_s;

   // Split buffered entries into schedulable ones and address-zero drops
   always_comb begin
      eligible_s = 4'b0000;
      drop_s     = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         if (buf_r[i].addr != {REG_SIZE_WIDTH{1'b0}}) begin
            eligible_s[i] = buf_valid_r[i];
         end else begin
            drop_s[i] = buf_valid_r[i];
         end
      end
   end

   rr_pick2 u_pick (
      .eligible     (eligible_s),
      .ptr          (ptr_r),
      .grant_first  (grant_first_s),
      .grant_second (grant_second_s),
      .valid_first  (valid_first_s),
      .valid_second (valid_second_s)
   );

   assign grant_s      = grant_first_s | grant_second_s;
   assign ready_s      = ~buf_valid_r | grant_s;
   assign req_ready_o  = ready_s;
   assign idx_first_s  = onehot_to_idx(grant_first_s);
   assign idx_second_s = onehot_to_idx(grant_second_s);
   assign busy_o       = |buf_valid_r;

   // Steer the granted buffers onto the two regfile write ports
   always_comb begin
      wr_first_valid_o    = valid_first_s;
      wr_second_valid_o   = valid_second_s;
      if (valid_first_s) begin
         wr_first_address_o = buf_r[idx_first_s].addr;
         wr_first_data_o    = buf_r[idx_first_s].data;
      end else begin
         wr_first_address_o = {REG_SIZE_WIDTH{1'b0}};
         wr_first_data_o    = {DATA_WIDTH{1'b0}};
      end
      if (valid_second_s) begin
         wr_second_address_o = buf_r[idx_second_s].addr;
         wr_second_data_o    = buf_r[idx_second_s].data;
      end else begin
         wr_second_address_o = {REG_SIZE_WIDTH{1'b0}};
         wr_second_data_o    = {DATA_WIDTH{1'b0}};
      end
   end

   // Holding buffers: capture on handshake, release on grant or drop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_valid_r <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            buf_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (req_valid_i[i] && ready_s[i]) begin
               buf_valid_r[i] <= 1'b1;
               buf_r[i].addr  <= req_addr_i[i*REG_SIZE_WIDTH +: REG_SIZE_WIDTH];
               buf_r[i].data  <= req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (grant_s[i] || drop_s[i]) begin
               buf_valid_r[i] <= 1'b0;
            end else begin
               buf_valid_r[i] <= buf_valid_r[i];
            end
         end
      end
   end

   // Rotate the priority pointer past the last index granted this cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_r <= 2'd0;
      end else if (valid_second_s) begin
         ptr_r <= idx_second_s + 2'd1;
      end else if (valid_first_s) begin
         ptr_r <= idx_first_s + 2'd1;
      end else begin
         ptr_r <= ptr_r;
      end
   end

`ifdef FP_WRB_PERF_CNT_EN
   logic stall_s;
   assign stall_s = |(req_valid_i & ~ready_s);

   // Count cycles where some producer is blocked, saturating at all-ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_o <= 32'd0;
      end else if (stall_s && (stall_cnt_o != 32'hFFFF_FFFF)) begin
         stall_cnt_o <= stall_cnt_o + 32'd1;
      end else begin
         stall_cnt_o <= stall_cnt_o;
      end
   end
`endif

endmodule

// File: tb/tb_fp_wrb_port_arbiter.sv
// tb_fp_wrb_port_arbiter: directed scenarios plus a randomized run checked
// against a queue-free slot model of the arbitration rules.
module tb_fp_wrb_port_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [23:0]  req_addr;
   logic [255:0] req_data;
   logic         wf_valid, ws_valid, busy;
   logic [5:0]   wf_addr, ws_addr;
   logic [63:0]  wf_data, ws_data;
`ifdef FP_WRB_PERF_CNT_EN
   logic [31:0]  stall_cnt;
`endif

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   fp_wrb_port_arbiter dut (
      .clk                 (clk),
      .rst                 (rst),
      .req_valid_i         (req_valid),
      .req_ready_o         (req_ready),
      .req_addr_i          (req_addr),
      .req_data_i          (req_data),
      .wr_first_valid_o    (wf_valid),
      .wr_first_address_o  (wf_addr),
      .wr_first_data_o     (wf_data),
      .wr_second_valid_o   (ws_valid),
      .wr_second_address_o (ws_addr),
      .wr_second_data_o    (ws_data),
`ifdef FP_WRB_PERF_CNT_EN
      .stall_cnt_o         (stall_cnt),
`endif
      .busy_o              (busy)
   );

   task automatic set_req(input int i, input logic v, input logic [5:0] a, input logic [63:0] d);
      req_valid[i]          = v;
      req_addr[i*6 +: 6]    = a;
      req_data[i*64 +: 64]  = d;
   endtask

   task automatic apply_reset();
      req_valid = 4'b0000;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      req_valid = 4'b0000; req_addr = '0; req_data = '0;
      apply_reset();
      vectors++; if (req_ready !== 4'b1111) begin errors++; $display("FAIL reset_ready got %b exp 1111", req_ready); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      @(negedge clk);
      set_req(0, 1'b1, 6'd7, 64'h1111);
      set_req(1, 1'b1, 6'd9, 64'h2222);
      @(negedge clk);
      req_valid = 4'b0000;
      vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL prereset_busy got %b exp 1", busy); end
      vectors++; if (wf_valid !== 1'b1 || ws_valid !== 1'b1) begin errors++; $display("FAIL prereset_ports got %b%b exp 11", wf_valid, ws_valid); end
      #1 rst = 1'b1;
      #1;
      vectors++; if (wf_valid !== 1'b0 || ws_valid !== 1'b0) begin errors++; $display("FAIL midreset_ports got %b%b exp 00", wf_valid, ws_valid); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b exp 0", busy); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++; if (req_ready !== 4'b1111) begin errors++; $display("FAIL release_ready got %b exp 1111", req_ready); end
   endtask

   task automatic test_single();
      @(negedge clk);
      set_req(0, 1'b1, 6'd5, 64'hDEAD);
      @(negedge clk);
      req_valid = 4'b0000;
      vectors++; if (wf_valid !== 1'b1) begin errors++; $display("FAIL single_first_valid got %b exp 1", wf_valid); end
      vectors++; if (wf_addr !== 6'd5) begin errors++; $display("FAIL single_first_addr got %0d exp 5", wf_addr); end
      vectors++; if (wf_data !== 64'hDEAD) begin errors++; $display("FAIL single_first_data got %h exp dead", wf_data); end
      vectors++; if (ws_valid !== 1'b0) begin errors++; $display("FAIL single_second_valid got %b exp 0", ws_valid); end
      @(negedge clk);
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b exp 0", busy); end
   endtask

   task automatic test_all_four();
      apply_reset();
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 6'(i + 1), 64'(100 + i));
      @(negedge clk);
      vectors++; if (wf_valid !== 1'b1 || wf_addr !== 6'd1) begin errors++; $display("FAIL all4_c1_first got %b/%0d exp 1/1", wf_valid, wf_addr); end
      vectors++; if (ws_valid !== 1'b1 || ws_addr !== 6'd2) begin errors++; $display("FAIL all4_c1_second got %b/%0d exp 1/2", ws_valid, ws_addr); end
      vectors++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL all4_c1_ready got %b exp 0011", req_ready); end
      req_valid[0] = 1'b0; req_valid[1] = 1'b0;
      @(negedge clk);
      req_valid = 4'b0000;
      vectors++; if (wf_valid !== 1'b1 || wf_addr !== 6'd3 || wf_data !== 64'd102) begin errors++; $display("FAIL all4_c2_first got %b/%0d exp 1/3", wf_valid, wf_addr); end
      vectors++; if (ws_valid !== 1'b1 || ws_addr !== 6'd4 || ws_data !== 64'd103) begin errors++; $display("FAIL all4_c2_second got %b/%0d exp 1/4", ws_valid, ws_addr); end
      @(negedge clk);
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL all4_idle_busy got %b exp 0", busy); end
      // pointer back at 0: producer 0 must win over producer 3
      set_req(0, 1'b1, 6'd10, 64'hA0);
      set_req(3, 1'b1, 6'd11, 64'hA3);
      @(negedge clk);
      req_valid = 4'b0000;
      vectors++; if (wf_addr !== 6'd10 || ws_addr !== 6'd11) begin errors++; $display("FAIL all4_ptr_wrap got %0d,%0d exp 10,11", wf_addr, ws_addr); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [5:0] a2, a3;
      for (int c = 0; c < 8; c++) begin
         a2 = 6'(1 + $urandom_range(0, 62));
         a3 = 6'(1 + $urandom_range(0, 62));
         set_req(2, 1'b1, a2, {$urandom, $urandom});
         set_req(3, 1'b1, a3, {$urandom, $urandom});
         @(negedge clk);
         vectors++; if (wf_valid !== 1'b1 || ws_valid !== 1'b1) begin errors++; $display("FAIL b2b_ports c%0d got %b%b exp 11", c, wf_valid, ws_valid); end
         vectors++; if (req_ready[3:2] !== 2'b11) begin errors++; $display("FAIL b2b_ready c%0d got %b exp 11", c, req_ready[3:2]); end
         vectors++;
         if (!((wf_addr === a2 && ws_addr === a3) || (wf_addr === a3 && ws_addr === a2))) begin
            errors++; $display("FAIL b2b_addrs c%0d got %0d,%0d exp {%0d,%0d}", c, wf_addr, ws_addr, a2, a3);
         end
      end
      req_valid = 4'b0000;
      @(negedge clk);
   endtask

   task automatic test_addr_zero();
      set_req(2, 1'b1, 6'd0, 64'hBEEF);
      @(negedge clk);
      req_valid = 4'b0000;
      vectors++; if (wf_valid !== 1'b0 || ws_valid !== 1'b0) begin errors++; $display("FAIL zero_ports got %b%b exp 00", wf_valid, ws_valid); end
      vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy_held got %b exp 1", busy); end
      @(negedge clk);
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_after got %b exp 0", busy); end
      vectors++; if (wf_valid !== 1'b0) begin errors++; $display("FAIL zero_ports_after got %b exp 0", wf_valid); end
   endtask

   task automatic test_random();
      bit          mv [4];
      logic [5:0]  ma [4];
      logic [63:0] md [4];
      int          age [4];
      int          mptr, first, second, idx;
      logic [3:0]  exp_ready;
      apply_reset();
      mptr = 0;
      for (int i = 0; i < 4; i++) begin mv[i] = 1'b0; ma[i] = '0; md[i] = '0; age[i] = 0; end
      for (int c = 0; c < 400; c++) begin
         first = -1; second = -1;
         for (int k = 0; k < 4; k++) begin
            idx = (mptr + k) % 4;
            if (mv[idx] && ma[idx] != 6'd0) begin
               if (first < 0) first = idx;
               else if (second < 0) second = idx;
            end
         end
         for (int i = 0; i < 4; i++) exp_ready[i] = !mv[i] || i == first || i == second;
         vectors++; if (wf_valid !== (first >= 0)) begin errors++; $display("FAIL rnd_first_valid c%0d got %b exp %b", c, wf_valid, first >= 0); end
         vectors++; if (ws_valid !== (second >= 0)) begin errors++; $display("FAIL rnd_second_valid c%0d got %b exp %b", c, ws_valid, second >= 0); end
         if (first >= 0) begin
            vectors++;
            if (wf_addr !== ma[first] || wf_data !== md[first]) begin errors++; $display("FAIL rnd_first_payload c%0d got %0d/%h exp %0d/%h", c, wf_addr, wf_data, ma[first], md[first]); end
         end
         if (second >= 0) begin
            vectors++;
            if (ws_addr !== ma[second] || ws_data !== md[second]) begin errors++; $display("FAIL rnd_second_payload c%0d got %0d/%h exp %0d/%h", c, ws_addr, ws_data, ma[second], md[second]); end
         end
         vectors++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready c%0d got %b exp %b", c, req_ready, exp_ready); end
         vectors++; if (busy !== (mv[0] | mv[1] | mv[2] | mv[3])) begin errors++; $display("FAIL rnd_busy c%0d got %b", c, busy); end
         // fairness: an eligible entry never waits two full cycles
         for (int i = 0; i < 4; i++) begin
            if (mv[i] && ma[i] != 6'd0 && i != first && i != second) age[i]++;
            else age[i] = 0;
            if (age[i] >= 2) begin
               vectors++; errors++; $display("FAIL rnd_fairness c%0d producer %0d waited %0d", c, i, age[i]);
            end
         end
         // new stimulus; blocked producers keep their request stable
         for (int i = 0; i < 4; i++) begin
            if (!(req_valid[i] && !exp_ready[i])) begin
               set_req(i, ($urandom_range(0, 2) != 0),
                       ($urandom_range(0, 7) == 0) ? 6'd0 : 6'(1 + $urandom_range(0, 62)),
                       {$urandom, $urandom});
            end
         end
         // advance the model across the coming edge
         for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && exp_ready[i]) begin
               mv[i] = 1'b1; ma[i] = req_addr[i*6 +: 6]; md[i] = req_data[i*64 +: 64];
            end else if (i == first || i == second || (mv[i] && ma[i] == 6'd0)) begin
               mv[i] = 1'b0;
            end
         end
         if (second >= 0) mptr = (second + 1) % 4;
         else if (first >= 0) mptr = (first + 1) % 4;
         @(negedge clk);
      end
      req_valid = 4'b0000;
      repeat (3) @(negedge clk);
   endtask

`ifdef FP_WRB_PERF_CNT_EN
   task automatic test_perf_cnt();
      apply_reset();
      vectors++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL perf_reset got %0d exp 0", stall_cnt); end
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 6'(20 + i), 64'(i));
      // first edge fills the empty buffers, each later edge sees two blocked producers
      repeat (11) @(negedge clk);
      vectors++; if (stall_cnt !== 32'd10) begin errors++; $display("FAIL perf_count got %0d exp 10", stall_cnt); end
      req_valid = 4'b0000;
      repeat (3) @(negedge clk);
      vectors++; if (stall_cnt !== 32'd10) begin errors++; $display("FAIL perf_hold got %0d exp 10", stall_cnt); end
   endtask
`endif

   initial begin
      rst = 1'b1;
      req_valid = 4'b0000;
      req_addr = '0;
      req_data = '0;
      test_reset();
      test_single();
      test_all_four();
      test_back_to_back();
      test_addr_zero();
      test_random();
`ifdef FP_WRB_PERF_CNT_EN
      test_perf_cnt();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
